rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
- Staged reset-release sequencer for the 100BASE-FX talker.
- Holds three downstream active-low synchronous resets low until PLL lock has been stable for a programmable time.
- Then releases them in order (clock/PLL-dependent logic, then MAC/encoder, then packet generator), with a fixed gap between stages.
- Re-asserts all three on lock loss or on a soft-reset request from the control logic.

Parameters:
- HOLD_CYCLES, 1024, cycles of continuous synchronized lock required before the first release (min 1).
- STAGE_GAP, 16, cycles between successive stage releases (min 1).

Ports:
- i_clk  in  1  system clock; only clock.
- i_rst  in  1  asynchronous, active-high reset; one clock, no other clock domains.
- i_pll_lock  in  1  PLL lock, asynchronous to i_clk; synchronized internally.
- i_sw_rst  in  1  single-cycle soft-reset request, synchronous to i_clk.
- o_res_n  out  3  staged active-low resets; bit0 released first, bit2 last.
- o_done  out  1  high when all stages are released (state RUN).
- o_lock_err  out  1  lock-timeout flag (see Optional Feature).

Behaviour:
- i_rst high (asynchronous): o_res_n=3'b000, o_done=0, o_lock_err=0, sync FFs=0, counter=0, state=WAIT_LOCK.
- All outputs are registered directly from FFs; no combinational glitches.
- Lock sync: 2-FF synchronizer, giving lock_s. i_pll_lock to lock_s latency is 2 edges.
- Counter: width clog2(max(HOLD_CYCLES, STAGE_GAP, LOCK_TIMEOUT)); it never wraps. It is cleared on every state change.
- WAIT_LOCK: o_res_n=000, o_done=0. When lock_s=1, go to STRETCH with cnt=0.
- STRETCH: cnt increments each cycle.
  - lock_s=0: back to WAIT_LOCK.
  - cnt==HOLD_CYCLES-1: go to GAP1 and set o_res_n[0]=1 on that same edge.
- GAP1: cnt counts. At cnt==STAGE_GAP-1, set o_res_n[1]=1 and go to GAP2.
- GAP2: at cnt==STAGE_GAP-1, set o_res_n[2]=1 and o_done=1, and go to RUN.
- RUN: holds o_res_n=111, o_done=1.
- Abort condition: lock_s=0 or i_sw_rst=1, evaluated in any state other than WAIT_LOCK.
  - On the next edge: o_res_n=000, o_done=0, state=WAIT_LOCK, cnt=0.
  - This applies mid-sequence too; partially released stages drop together.
- Simultaneous lock loss and i_sw_rst: one abort, same effect.
- i_sw_rst in WAIT_LOCK: ignored.
- Soft reset with lock held: WAIT_LOCK, then STRETCH on the following edge. The full HOLD_CYCLES plus gaps are repeated.
- Release timing, lock stable at i_rst fall, edges counted from the first edge after deassert:
  - o_res_n[0] rises at edge 3+HOLD_CYCLES.
  - o_res_n[1] rises at edge 3+HOLD_CYCLES+STAGE_GAP.
  - o_res_n[2] and o_done rise at edge 3+HOLD_CYCLES+2*STAGE_GAP.
- Release order is strictly monotonic: a higher stage is never released while a lower one is asserted.

Optional Feature:
- Macro: RSTSEQ_LOCK_TIMEOUT_EN.
- Defined:
  - Adds parameter LOCK_TIMEOUT (default 65536).
  - In WAIT_LOCK, cnt counts while lock_s=0. When cnt==LOCK_TIMEOUT-1, o_lock_err is set.
  - o_lock_err is sticky until i_rst and does not affect sequencing; lock arriving later still proceeds normally.
- Not defined: o_lock_err is tied 0, there is no WAIT_LOCK counting, and the port is still present.

Test Plan (HOLD_CYCLES=8, STAGE_GAP=4, LOCK_TIMEOUT=32 where enabled):
- Lock high, i_rst released -> o_res_n goes 000→001 at edge 11, 011 at edge 15, 111 with o_done=1 at edge 19; never non-monotonic.
- i_rst asserted mid-GAP2 -> o_res_n=000 and o_done=0 immediately (async, no clock edge); after release the full sequence reruns from edge 1.
- Lock drops for 1 cycle at STRETCH cnt=5 -> returns to WAIT_LOCK; o_res_n[0] rises 8 cycles after lock_s returns high; no early release.
- In RUN, i_sw_rst pulse -> o_res_n=000 and o_done=0 on next edge; o_res_n[0] rises 1+8 edges later, o_done 8 edges after that.
- In RUN, lock falls while i_sw_rst pulses the same cycle -> single abort to 000; resequences only after lock_s returns.
- With RSTSEQ_LOCK_TIMEOUT_EN, lock held low 40 cycles after i_rst release -> o_lock_err=1 at edge 32 and stays 1 after lock arrives and o_done=1; it clears only on i_rst. Without the macro -> o_lock_err stays 0.

Source files
------------

// File: rtl/rst_seq.sv
// Staged reset-release sequencer: holds three active-low resets until PLL lock is stable, then releases them in order.
// Optional lock-timeout flag enabled by defining RSTSEQ_LOCK_TIMEOUT_EN.
module rst_seq #(
  parameter int HOLD_CYCLES  = 1024,
  parameter int STAGE_GAP    = 16
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  ,
  parameter int LOCK_TIMEOUT = 65536
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_lock,
  input  logic       i_sw_rst,
  output logic [2:0] o_res_n,
  output logic       o_done,
  output logic       o_lock_err
);

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam int TO_CYCLES = LOCK_TIMEOUT;
`else
  localparam int TO_CYCLES = 1;
`endif
  localparam int SEQ_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX = (SEQ_MAX > TO_CYCLES) ? SEQ_MAX : TO_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STRETCH,
    GAP1,
    GAP2,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_sat;
  logic [2:0]      res_d;
  logic            done_d;
  logic            err_d;
  logic            lock_meta, lock_s;
  logic            abort;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= i_pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Saturating increment: the counter must never wrap back to zero.
  assign cnt_sat = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign abort   = !lock_s || i_sw_rst;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_sat;
    res_d   = o_res_n;
    done_d  = o_done;
    err_d   = o_lock_err;

    unique case (state_q)
      WAIT_LOCK: begin
        res_d  = 3'b000;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        if (lock_s) begin
          state_d = STRETCH;
          cnt_d   = '0;
        end
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
        else begin
          cnt_d = cnt_sat;
          if (cnt_q == TO_LAST) err_d = 1'b1;
        end
`endif
      end
      STRETCH: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP1;
          cnt_d   = '0;
          res_d   = 3'b001;
        end
      end
      GAP1: begin
        if (cnt_q == GAP_LAST) begin
          state_d = GAP2;
          cnt_d   = '0;
          res_d   = 3'b011;
        end
      end
      GAP2: begin
        if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          res_d   = 3'b111;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        res_d   = 3'b000;
        done_d  = 1'b0;
      end
    endcase

    // Abort drops every stage together, wherever the sequence has got to.
    if (state_q != WAIT_LOCK && abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      res_d   = 3'b000;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      o_res_n    <= 3'b000;
      o_done     <= 1'b0;
      o_lock_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_res_n    <= res_d;
      o_done     <= done_d;
      o_lock_err <= err_d;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues expected output changes with their edge numbers, a monitor checks them.
module tb_rst_seq;

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Output word layout: {o_lock_err, o_done, o_res_n}
  localparam logic [4:0] ST0  = 5'b00000;
  localparam logic [4:0] ST1  = 5'b00001;
  localparam logic [4:0] ST2  = 5'b00011;
  localparam logic [4:0] ST3  = 5'b01111;
  localparam logic [4:0] ERRB = 5'b10000;

  typedef struct {
    int         at;
    logic [4:0] val;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_pll_lock = 1'b0;
  logic       i_sw_rst = 1'b0;
  logic [2:0] o_res_n;
  logic       o_done;
  logic       o_lock_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   base = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];
  logic [4:0] model = ST0;

  rst_seq #(
    .HOLD_CYCLES(8),
    .STAGE_GAP(4)
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    ,
    .LOCK_TIMEOUT(32)
`endif
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pll_lock (i_pll_lock),
    .i_sw_rst   (i_sw_rst),
    .o_res_n    (o_res_n),
    .o_done     (o_done),
    .o_lock_err (o_lock_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req,
                       input int act_at, input int req_at);
    checks++;
    if (act !== req || act_at != req_at) begin
      errors++;
      $display("FAIL %s: got %b at edge %0d, expected %b at edge %0d", name, act, act_at, req, req_at);
    end
  endtask

  // Queue an expected output change; unchanged values are not queued.
  task automatic expect_out(input int at, input logic [4:0] val);
    exp_t e;
    if (val !== model) begin
      e.at  = at;
      e.val = val;
      sb_q.push_back(e);
      model = val;
    end
  endtask

  task automatic release_seq(input int t0, input logic [4:0] eb);
    expect_out(t0,     ST1 | eb);
    expect_out(t0 + 4, ST2 | eb);
    expect_out(t0 + 8, ST3 | eb);
  endtask

  // Returns at a negedge with the next rising edge being absolute edge k.
  task automatic wait_before(input int k);
    int guard = 0;
    while (cyc < k - 1 && guard < 20000) begin
      @(negedge i_clk);
      guard++;
    end
  endtask

  // Asserts i_rst mid-cycle, checks the asynchronous clear, releases at a negedge.
  task automatic do_reset(input logic lock_val, input string name);
    @(posedge i_clk);
    #1;
    i_rst      = 1'b1;
    i_sw_rst   = 1'b0;
    i_pll_lock = lock_val;
    expect_out(cyc, ST0);
    #1;
    check(name, {o_lock_err, o_done, o_res_n}, ST0, cyc, cyc);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    base  = cyc;
  endtask

  // Monitor: legal-shape check every cycle, scoreboard pop on every output change.
  initial begin
    logic [4:0] cur;
    logic [4:0] prev;
    exp_t       e;
    prev = ST0;
    wait (mon_en);
    forever begin
      @(negedge i_clk);
      cur = {o_lock_err, o_done, o_res_n};
      checks++;
      if (!((cur[2:0] == 3'b000 || cur[2:0] == 3'b001 || cur[2:0] == 3'b011 || cur[2:0] == 3'b111)
            && (cur[3] == (cur[2:0] == 3'b111)))) begin
        errors++;
        $display("FAIL shape: outputs %b at edge %0d are not a monotonic release state", cur, cyc);
      end
      if (cur !== prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %b at edge %0d, expected no change from %b", cur, cyc, prev);
        end else begin
          e = sb_q.pop_front();
          check("transition", cur, e.val, cyc, e.at);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_sw, l_fall, r_rise;

    // Full sequence from i_rst release with lock already stable
    do_reset(1'b1, "reset_state");
    mon_en = 1'b1;
    release_seq(base + 11, ST0);
    wait_before(base + 24);

    // Soft reset in RUN
    e_sw = cyc + 1;
    i_sw_rst = 1'b1;
    expect_out(e_sw, ST0);
    release_seq(e_sw + 9, ST0);
    @(negedge i_clk);
    i_sw_rst = 1'b0;
    wait_before(e_sw + 22);

    // Lock loss and soft reset seen on the same edge; soft reset in WAIT_LOCK ignored
    l_fall = cyc + 1;
    i_pll_lock = 1'b0;
    wait_before(l_fall + 2);
    i_sw_rst = 1'b1;
    expect_out(l_fall + 2, ST0);
    @(negedge i_clk);
    i_sw_rst = 1'b0;
    wait_before(l_fall + 6);
    i_sw_rst = 1'b1;
    @(negedge i_clk);
    i_sw_rst = 1'b0;
    r_rise = l_fall + 12;
    wait_before(r_rise);
    i_pll_lock = 1'b1;
    release_seq(r_rise + 10, ST0);
    wait_before(r_rise + 22);

    // Async reset mid-GAP2, then a full rerun from edge 1
    do_reset(1'b1, "reset_from_run");
    expect_out(base + 11, ST1);
    expect_out(base + 15, ST2);
    wait_before(base + 17);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    expect_out(cyc, ST0);
    #1;
    check("async_reset_gap2", {o_lock_err, o_done, o_res_n}, ST0, cyc, cyc);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    base  = cyc;
    release_seq(base + 11, ST0);
    wait_before(base + 24);

    // One-cycle lock glitch while STRETCH holds cnt=5
    do_reset(1'b1, "reset_glitch");
    wait_before(base + 7);
    i_pll_lock = 1'b0;
    @(negedge i_clk);
    i_pll_lock = 1'b1;
    release_seq(base + 18, ST0);
    wait_before(base + 30);

    // Late lock: timeout flag (when built in) is sticky through RUN and cleared only by i_rst
    do_reset(1'b0, "reset_nolock");
    if (TO_EN) expect_out(base + 32, ERRB);
    wait_before(base + 41);
    i_pll_lock = 1'b1;
    release_seq(base + 51, TO_EN ? ERRB : ST0);
    wait_before(base + 62);
    do_reset(1'b1, "reset_clears_err");
    repeat (4) @(negedge i_clk);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected changes never seen, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
